// File: rtl/fifo_pkg.sv
// Shared defaults and the occupancy-to-status-flag helper for the FIFO controller.
package fifo_pkg;

  localparam int unsigned FIFO_ADDR_WIDTH = 5;
  localparam int unsigned FIFO_DEPTH      = 32;
  localparam int unsigned FIFO_AF_MARGIN  = 4;
  localparam int unsigned FIFO_AE_MARGIN  = 4;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

  // Written as count + margin >= depth so a margin larger than depth cannot underflow.
  function automatic fifo_flags_t occ_flags(input int unsigned count,
                                            input int unsigned depth,
                                            input int unsigned af_margin,
                                            input int unsigned ae_margin);
    fifo_flags_t f;
    f.full         = (count == depth);
    f.empty        = (count == 0);
    f.almost_full  = ((count + af_margin) >= depth);
    f.almost_empty = (count <= ae_margin);
    return f;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer with increment enable; the MSB is the lap bit.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = FIFO_ADDR_WIDTH + 1
) (
  input  logic             clk_write,
  input  logic             RST,
  input  logic             inc,
  output logic [WIDTH-1:0] ptr
);

  always_ff @(posedge clk_write or posedge RST) begin
    if (RST) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + WIDTH'(1);
    end
  end

endmodule

// File: rtl/fifo_ctrl.sv
// Single-clock FIFO controller: RAM address/enable generation plus registered status.
// Optional sticky overflow/underflow flags are built when FIFO_CTRL_ERR_FLAGS_EN is defined.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int unsigned DEPTH      = FIFO_DEPTH,
  parameter int unsigned AF_MARGIN  = FIFO_AF_MARGIN,
  parameter int unsigned AE_MARGIN  = FIFO_AE_MARGIN
) (
  input  logic                  clk_write,
  input  logic                  RST,
  input  logic                  i_push,
  input  logic                  i_pop,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  output logic                  o_rd_en,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_almost_full,
  output logic                  o_almost_empty,
`ifdef FIFO_CTRL_ERR_FLAGS_EN
  input  logic                  i_err_clr,
  output logic                  o_overflow,
  output logic                  o_underflow,
`endif
  output logic [ADDR_WIDTH:0]   o_count
);

  localparam int unsigned PTR_W = ADDR_WIDTH + 1;

  if (DEPTH != (1 << ADDR_WIDTH)) begin : g_depth_check
    $error("fifo_ctrl: DEPTH must equal 2**ADDR_WIDTH");
  end

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] count_d;
  logic             push_ok;
  logic             pop_ok;
  fifo_flags_t      flags_d;

  // Accept decisions use only registered status, so a push into a full FIFO
  // succeeds only when a same-cycle pop frees the slot.
  always_comb begin
    pop_ok  = 1'b0;
    push_ok = 1'b0;
    if (!RST) begin
      pop_ok  = i_pop & ~o_empty;
      push_ok = i_push & (~o_full | pop_ok);
    end
  end

  assign o_wr_en   = push_ok;
  assign o_rd_en   = pop_ok;
  assign o_wr_addr = wr_ptr[ADDR_WIDTH-1:0];
  assign o_rd_addr = rd_ptr[ADDR_WIDTH-1:0];

  fifo_ptr #(.WIDTH(PTR_W)) u_wr_ptr (
    .clk_write (clk_write),
    .RST       (RST),
    .inc       (push_ok),
    .ptr       (wr_ptr)
  );

  fifo_ptr #(.WIDTH(PTR_W)) u_rd_ptr (
    .clk_write (clk_write),
    .RST       (RST),
    .inc       (pop_ok),
    .ptr       (rd_ptr)
  );

  always_comb begin
    count_d = o_count + PTR_W'(push_ok) - PTR_W'(pop_ok);
    flags_d = occ_flags(32'(count_d), DEPTH, AF_MARGIN, AE_MARGIN);
  end

  // Flags come from the next count so they are valid right after the update edge.
  always_ff @(posedge clk_write or posedge RST) begin
    if (RST) begin
      o_count        <= '0;
      o_full         <= 1'b0;
      o_empty        <= 1'b1;
      o_almost_full  <= 1'b0;
      o_almost_empty <= 1'b1;
    end else begin
      o_count        <= count_d;
      o_full         <= flags_d.full;
      o_empty        <= flags_d.empty;
      o_almost_full  <= flags_d.almost_full;
      o_almost_empty <= flags_d.almost_empty;
    end
  end

`ifdef FIFO_CTRL_ERR_FLAGS_EN
  // Sticky error flags; clear wins over a same-cycle set.
  always_ff @(posedge clk_write or posedge RST) begin
    if (RST) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else if (i_err_clr) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (i_push && !push_ok) o_overflow  <= 1'b1;
      if (i_pop  && !pop_ok)  o_underflow <= 1'b1;
    end
  end
`else
  // Rejected requests are dropped with no indication.
`endif

  // Occupancy must always match the pointer distance.
  a_count_matches_ptrs: assert property (@(posedge clk_write) disable iff (RST)
    o_count == PTR_W'(wr_ptr - rd_ptr));

endmodule
